dmem_mmio: RTL and testbench
============================

Name: dmem_mmio

Overview:
Data-side memory system directly downstream of the single-cycle MIPS core. It consumes the core's memwrite, aluout (address) and writedata, and returns readdata in the same cycle. It decodes each access to either a word-addressed data RAM or a small bank of memory-mapped peripherals:
- LED register
- synchronised switch input
- free-running cycle counter
- reloadable countdown timer with expiry flag

Parameters:
RAM_WORDS, 64, number of 32-bit words in data RAM (power of two, 16..1024)
MMIO_BASE, 32'hFFFF_0000, base address of the peripheral bank

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
memwrite  input  1  write strobe from core, sampled at rising edge
addr  input  32  byte address (core aluout); addr[1:0] ignored, word accesses only
writedata  input  32  store data from core
readdata  output  32  combinational read data for addr
switches  input  16  asynchronous board switches
leds  output  16  LED register contents
timer_irq  output  1  timer expiry flag (level)

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high. Reads are combinational in the same cycle. Writes commit at the rising edge when memwrite=1.
- Address decode (word index = addr[31:2]):
  - RAM region: addr < RAM_WORDS*4. RAM index = addr[log2(RAM_WORDS)+1:2].
  - MMIO_BASE+0x00 LED: R/W. Bits[15:0] drive leds; reads return {16'b0, led}.
  - +0x04 SWITCH: RO. Reads {16'b0, sw_sync}. Writes ignored.
  - +0x08 CYCLES: Reads the 32-bit counter. Any write clears it.
  - +0x0C RELOAD: R/W 32-bit. A write also loads tcount with writedata.
  - +0x10 STATUS: Reads {30'b0, enable, expired}. On write: bit1 -> enable; bit0=1 clears expired (W1C); bit0=0 leaves expired unchanged.
  - Any other address: reads 0, writes ignored, no side effects.
- Reset values:
  - led = 0, so leds = 0
  - cycles = 0, reload = 0, tcount = 0, enable = 0, expired = 0, so timer_irq = 0
  - both sync flops = 0
  - RAM contents are NOT reset: undefined until written
  - readdata follows decode, so MMIO reads return reset values in the cycle after reset.
- Switch sync: two-flop chain. A switch change is visible on SWITCH reads 2 edges later.
- Cycle counter:
  - Increments by 1 every non-reset edge; wraps 0xFFFF_FFFF -> 0.
  - A write to CYCLES forces 0 at that edge (write beats increment). A same-cycle read returns the old value.
- Timer (evaluated at each non-reset edge, priority top-down):
  1. Write to RELOAD: reload <= wd, tcount <= wd. No decrement or expiry check this edge.
  2. enable=1 and tcount==0: expired <= 1, tcount <= reload.
  3. enable=1 and tcount!=0: tcount <= tcount-1.
  4. enable=0: tcount holds.
  - Period = reload+1 cycles. reload=0 with enable=1 expires every cycle.
  - An expiry and a W1C write in the same edge: set wins, expired stays 1.
  - An enable write takes effect from the next edge.
- timer_irq = expired; it stays high until cleared or reset.
- RAM write: ram[index] <= writedata at the edge. A same-cycle read of the same word returns the old data.
- A reset asserted mid-operation overrides all writes in that cycle.

Test Plan:
- Reset, then read 0xFFFF0000 / 0xFFFF0008 / 0xFFFF0010 in the next cycle -> 0 / 0 / 0; leds=0, timer_irq=0.
- Write 0xDEADBEEF to addr 0x10, read 0x10 next cycle -> 0xDEADBEEF; read 0x13 -> 0xDEADBEEF; write to 0x8000_0000 ignored, read -> 0.
- Write 0x1234ABCD to LED -> leds=0xABCD, LED read=0x0000ABCD. switches=0x00F0 -> SWITCH read 0 after 1 edge, 0x00F0 after 2.
- Free-run 10 edges after reset -> CYCLES=10. Write CYCLES -> next-cycle read 0, then 1.
- RELOAD=3, STATUS write 0x2 -> timer_irq rises exactly 4 cycles after enable takes effect, and again 4 cycles later. Write STATUS 0x3 on an expiry edge -> irq stays 1; write 0x3 on a non-expiry edge -> irq 0 next cycle.
- Assert reset while timer enabled and LED=0xFFFF -> next edge: leds=0, timer_irq=0, STATUS read 0, CYCLES restarts from 0.

Source files
------------

// File: rtl/dmem_mmio.sv
// Data-side memory for the single-cycle core: word RAM plus
// a small MMIO bank (LEDs, switches, cycle counter, timer).
module dmem_mmio #(
  parameter int          RAM_WORDS = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] switches,
  output logic [15:0] leds,
  output logic        timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] ram_q [RAM_WORDS];

  logic [15:0] led_q, led_d;
  logic [15:0] sw1_q, sw2_q;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] rel_q, rel_d;
  logic [31:0] tc_q, tc_d;
  logic        en_q, en_d;
  logic        exp_q, exp_d;

  logic          ram_hit;
  logic [AW-1:0] ram_idx;
  logic [29:0]   woff;
  logic          mmio_hit;
  logic          sel_led, sel_sw, sel_cyc;
  logic          sel_rel, sel_st;
  logic          fire;
  logic          unused_ok;

  assign unused_ok = ^addr[1:0];

  assign ram_hit = (addr[31:AW+2] == '0);
  assign ram_idx = addr[AW+1:2];

  // Word offset from the bank base; five registers live at 0..4.
  assign woff     = addr[31:2] - MMIO_BASE[31:2];
  assign mmio_hit = !ram_hit && (woff[29:3] == '0);
  assign sel_led  = mmio_hit && (woff[2:0] == 3'd0);
  assign sel_sw   = mmio_hit && (woff[2:0] == 3'd1);
  assign sel_cyc  = mmio_hit && (woff[2:0] == 3'd2);
  assign sel_rel  = mmio_hit && (woff[2:0] == 3'd3);
  assign sel_st   = mmio_hit && (woff[2:0] == 3'd4);

  always_comb begin
    readdata = '0;
    unique case (1'b1)
      ram_hit: readdata = ram_q[ram_idx];
      sel_led: readdata = {16'b0, led_q};
      sel_sw:  readdata = {16'b0, sw2_q};
      sel_cyc: readdata = cyc_q;
      sel_rel: readdata = rel_q;
      sel_st:  readdata = {30'b0, en_q, exp_q};
      default: readdata = '0;
    endcase
  end

  always_comb begin
    led_d = led_q;
    cyc_d = cyc_q + 32'd1;
    rel_d = rel_q;
    tc_d  = tc_q;
    en_d  = en_q;
    exp_d = exp_q;
    fire  = 1'b0;
    if (memwrite && sel_led) led_d = writedata[15:0];
    if (memwrite && sel_cyc) cyc_d = '0;
    if (memwrite && sel_rel) begin
      rel_d = writedata;
      tc_d  = writedata;
    end else if (en_q) begin
      if (tc_q == '0) begin
        fire = 1'b1;
        tc_d = rel_q;
      end else begin
        tc_d = tc_q - 32'd1;
      end
    end
    if (memwrite && sel_st) begin
      en_d = writedata[1];
      if (writedata[0]) exp_d = 1'b0;
    end
    // An expiry on the same edge as a clear keeps the flag set.
    if (fire) exp_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
      sw1_q <= '0;
      sw2_q <= '0;
      cyc_q <= '0;
      rel_q <= '0;
      tc_q  <= '0;
      en_q  <= 1'b0;
      exp_q <= 1'b0;
    end else begin
      led_q <= led_d;
      sw1_q <= switches;
      sw2_q <= sw1_q;
      cyc_q <= cyc_d;
      rel_q <= rel_d;
      tc_q  <= tc_d;
      en_q  <= en_d;
      exp_q <= exp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && memwrite && ram_hit) ram_q[ram_idx] <= writedata;
  end

  assign leds      = led_q;
  assign timer_irq = exp_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed vector table, timer/switch/reset
// sequences, then random traffic against a reference model.
module tb_dmem_mmio;

  localparam logic [31:0] A_LED = 32'hFFFF_0000;
  localparam logic [31:0] A_SW  = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC = 32'hFFFF_0008;
  localparam logic [31:0] A_REL = 32'hFFFF_000C;
  localparam logic [31:0] A_ST  = 32'hFFFF_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] switches;
  logic [15:0] leds;
  logic        timer_irq;

  dmem_mmio #(.RAM_WORDS(64), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .readdata(readdata), .switches(switches),
    .leds(leds), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: one variable per architectural register.
  logic [31:0] m_ram [64];
  bit          m_val [64];
  logic [15:0] m_led, m_s1, m_s2;
  logic [31:0] m_cyc, m_rel, m_tc;
  logic        m_en, m_exp;
  logic [31:0] rd_seen;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a,
                                         output bit known);
    logic [31:0] w;
    known = 1'b1;
    w = {a[31:2], 2'b00};
    if (a < 32'd256) begin
      known = m_val[a[7:2]];
      return m_ram[a[7:2]];
    end
    case (w)
      A_LED:   return {16'b0, m_led};
      A_SW:    return {16'b0, m_s2};
      A_CYC:   return m_cyc;
      A_REL:   return m_rel;
      A_ST:    return {30'b0, m_en, m_exp};
      default: return 32'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_led = 0; m_s1 = 0; m_s2 = 0;
    m_cyc = 0; m_rel = 0; m_tc = 0;
    m_en = 0; m_exp = 0;
  endtask

  task automatic m_edge(input bit rst, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [15:0] sw);
    logic [31:0] w;
    bit expire;
    if (rst) begin
      m_reset();
      return;
    end
    w = {a[31:2], 2'b00};
    m_s2 = m_s1;
    m_s1 = sw;
    m_cyc = (we && w == A_CYC) ? 32'd0 : m_cyc + 32'd1;
    if (we && a < 32'd256) begin
      m_ram[a[7:2]] = wd;
      m_val[a[7:2]] = 1'b1;
    end
    if (we && w == A_LED) m_led = wd[15:0];
    expire = 1'b0;
    if (we && w == A_REL) begin
      m_rel = wd;
      m_tc = wd;
    end else if (m_en && m_tc == 0) begin
      expire = 1'b1;
      m_tc = m_rel;
    end else if (m_en) begin
      m_tc = m_tc - 1;
    end
    if (we && w == A_ST) begin
      m_en = wd[1];
      if (wd[0]) m_exp = 1'b0;
    end
    if (expire) m_exp = 1'b1;
  endtask

  // One bus cycle: read checked before the edge, outputs after it.
  task automatic step(input bit rst, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [15:0] sw);
    logic [31:0] exp;
    bit known;
    @(negedge clk);
    reset = rst; memwrite = we; addr = a; writedata = wd; switches = sw;
    #1;
    rd_seen = readdata;
    exp = m_read(a, known);
    if (known) check("model_rdata", readdata, exp);
    @(posedge clk);
    m_edge(rst, we, a, wd, sw);
    #1;
    check("model_leds", {16'b0, leds}, {16'b0, m_led});
    check("model_irq", {31'b0, timer_irq}, {31'b0, m_exp});
  endtask

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] wd;
    bit          chk;
    logic [31:0] rd;
    logic [15:0] led;
  } vec_t;

  vec_t vt [15];

  initial begin
    vt[0]  = '{0, A_CYC, 0, 1, 32'd0, 16'h0};
    vt[1]  = '{0, A_LED, 0, 1, 32'd0, 16'h0};
    vt[2]  = '{0, A_ST, 0, 1, 32'd0, 16'h0};
    vt[3]  = '{1, 32'h10, 32'hDEADBEEF, 0, 32'd0, 16'h0};
    vt[4]  = '{0, 32'h10, 0, 1, 32'hDEADBEEF, 16'h0};
    vt[5]  = '{0, 32'h13, 0, 1, 32'hDEADBEEF, 16'h0};
    vt[6]  = '{1, 32'h8000_0000, 32'h55, 1, 32'd0, 16'h0};
    vt[7]  = '{0, 32'h8000_0000, 0, 1, 32'd0, 16'h0};
    vt[8]  = '{1, A_LED, 32'h1234ABCD, 1, 32'd0, 16'hABCD};
    vt[9]  = '{0, A_LED, 0, 1, 32'h0000ABCD, 16'hABCD};
    vt[10] = '{0, A_CYC, 0, 1, 32'd10, 16'hABCD};
    vt[11] = '{1, A_CYC, 32'h77, 1, 32'd11, 16'hABCD};
    vt[12] = '{0, A_CYC, 0, 1, 32'd0, 16'hABCD};
    vt[13] = '{0, A_CYC, 0, 1, 32'd1, 16'hABCD};
    vt[14] = '{0, A_SW, 0, 1, 32'd0, 16'hABCD};

    foreach (m_val[i]) m_val[i] = 1'b0;
    reset = 1; memwrite = 0; addr = 0; writedata = 0; switches = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_leds", {16'b0, leds}, 32'd0);
    check("rst_irq", {31'b0, timer_irq}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      step(0, vt[i].we, vt[i].a, vt[i].wd, 16'h0);
      if (vt[i].chk) check($sformatf("vec%0d_rd", i), rd_seen, vt[i].rd);
      check($sformatf("vec%0d_led", i), {16'b0, leds}, {16'b0, vt[i].led});
    end

    // Two-flop synchroniser latency
    step(0, 0, A_SW, 0, 16'h00F0);
    check("sw_edge0", rd_seen, 32'd0);
    step(0, 0, A_SW, 0, 16'h00F0);
    check("sw_edge1", rd_seen, 32'd0);
    step(0, 0, A_SW, 0, 16'h00F0);
    check("sw_edge2", rd_seen, 32'h00F0);

    // Timer: reload 3 gives a 4-cycle period
    step(0, 1, A_REL, 32'd3, 16'h00F0);
    step(0, 1, A_ST, 32'h2, 16'h00F0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, A_ST, 0, 16'h00F0);
      check($sformatf("tmr_e%0d_irq", k), {31'b0, timer_irq},
            (k == 4) ? 32'd1 : 32'd0);
    end
    step(0, 1, A_ST, 32'h3, 16'h00F0);
    check("tmr_clr_irq", {31'b0, timer_irq}, 32'd0);
    step(0, 0, A_REL, 0, 16'h00F0);
    check("tmr_e6_rd", rd_seen, 32'd3);
    step(0, 0, A_ST, 0, 16'h00F0);
    check("tmr_e7_irq", {31'b0, timer_irq}, 32'd0);
    step(0, 1, A_ST, 32'h3, 16'h00F0);
    check("tmr_setwins_irq", {31'b0, timer_irq}, 32'd1);
    step(0, 1, A_ST, 32'h3, 16'h00F0);
    check("tmr_clr2_irq", {31'b0, timer_irq}, 32'd0);

    // Reset while running overrides a pending write
    step(0, 1, A_LED, 32'hFFFF, 16'h00F0);
    check("led_ffff", {16'b0, leds}, 32'h0000FFFF);
    step(1, 1, A_LED, 32'h1234, 16'h00F0);
    check("mrst_leds", {16'b0, leds}, 32'd0);
    check("mrst_irq", {31'b0, timer_irq}, 32'd0);
    step(0, 0, A_CYC, 0, 16'h00F0);
    check("mrst_cyc0", rd_seen, 32'd0);
    step(0, 0, A_ST, 0, 16'h00F0);
    check("mrst_status", rd_seen, 32'd0);
    step(0, 0, A_CYC, 0, 16'h00F0);
    check("mrst_cyc2", rd_seen, 32'd2);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, wd;
      logic [15:0] sw;
      int r;
      bit we, rst;
      r = $urandom_range(0, 9);
      if (r < 4)
        a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      else if (r < 9)
        a = A_LED + 32'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
      else
        a = $urandom;
      wd = $urandom;
      if ({a[31:2], 2'b00} == A_REL) wd = wd & 32'h7;
      we = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 79) == 0);
      sw = ($urandom_range(0, 3) == 0) ? 16'($urandom) : switches;
      step(rst, we, a, wd, sw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
